// File: rtl/pci_target_mem_if_if.sv
// Core-side PCI target bus between the PCI core and a user memory target.
// The master modport is the PCI core; the slave modport is the memory target.
interface pci_target_mem_if_if #(
  parameter int DATA_W = 32
);
  logic                  base_hit;
  logic                  addr_vld;
  logic [31:0]           addr;
  logic                  s_wrdn;
  logic                  s_data;
  logic                  s_data_vld;
  logic [DATA_W/8-1:0]   s_cbe;
  logic [DATA_W-1:0]     adio_out;
  logic [DATA_W-1:0]     adio_in;
  logic                  c_ready;
  logic                  c_term;
  logic                  oe_adio;

  modport master (
    output base_hit, addr_vld, addr, s_wrdn, s_data, s_data_vld, s_cbe, adio_out,
    input  adio_in, c_ready, c_term, oe_adio
  );

  modport slave (
    input  base_hit, addr_vld, addr, s_wrdn, s_data, s_data_vld, s_cbe, adio_out,
    output adio_in, c_ready, c_term, oe_adio
  );
endinterface

// File: rtl/pci_target_mem_if.sv
// Burst-capable PCI target memory with zero-wait-state reads and top-of-memory disconnect.
// Optional PCI_MEM_BURST_LIMIT_EN adds a phase counter that disconnects after MAX_BURST phases.
module pci_target_mem_if #(
  parameter int DATA_W     = 32,
  parameter int DEPTH_LOG2 = 10,
  parameter int MAX_BURST  = 16
) (
  input logic            clk,
  input logic            rst_n,
  pci_target_mem_if_if.slave bus
);
  localparam int BYTES     = DATA_W / 8;
  localparam int BYTE_LOG2 = $clog2(BYTES);
  localparam int DEPTH     = 1 << DEPTH_LOG2;

  typedef enum logic [2:0] {IDLE, WRITE, RD_FETCH, READ, DRAIN} state_t;

  state_t                 state, state_next;
  logic [DEPTH_LOG2-1:0]  ptr;
  logic [DATA_W-1:0]      mem [DEPTH];
  logic [DATA_W-1:0]      rd_data;
  logic                   s_data_q;
  logic                   term_done;
  logic                   hit;
  logic                   s_data_fall;
  logic                   in_burst;
  logic                   read_burst;
  logic                   last_phase;
  logic                   phase_done;
  logic                   c_ready;
  logic                   c_term;
  logic                   oe_adio;
  logic                   unused_addr_bits;

  assign hit              = bus.base_hit && bus.addr_vld;
  assign s_data_fall      = s_data_q && !bus.s_data;
  assign unused_addr_bits = ^{bus.addr[31:DEPTH_LOG2+BYTE_LOG2], bus.addr[BYTE_LOG2-1:0]};

`ifdef PCI_MEM_BURST_LIMIT_EN
  localparam int CNT_W = $clog2(MAX_BURST + 1);
  logic [CNT_W-1:0] phase_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n || state == IDLE) begin
      phase_cnt <= '0;
    end else if (phase_done) begin
      phase_cnt <= phase_cnt + CNT_W'(1);
    end
  end

  assign last_phase = (ptr == '1) || (phase_cnt == CNT_W'(MAX_BURST - 1));
`else
  assign last_phase = (ptr == '1);
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // After the disconnecting phase completes, c_term is held until s_data drops.
  always_comb begin
    state_next = state;
    in_burst   = 1'b0;
    read_burst = 1'b0;
    case (state)
      IDLE: begin
        if (hit) begin
          state_next = bus.s_wrdn ? WRITE : RD_FETCH;
        end
      end
      WRITE: begin
        in_burst = bus.s_data;
        if (s_data_fall) state_next = DRAIN;
      end
      RD_FETCH: begin
        state_next = s_data_fall ? DRAIN : READ;
      end
      READ: begin
        in_burst   = bus.s_data;
        read_burst = bus.s_data;
        if (s_data_fall) state_next = DRAIN;
      end
      DRAIN: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    c_ready    = in_burst && !term_done;
    c_term     = in_burst && (term_done || last_phase);
    oe_adio    = read_burst;
    phase_done = c_ready && bus.s_data_vld;
  end

  // Writes land at the clock edge and reads fetch afterwards, so a read of a
  // just-written word always sees the new data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr       <= '0;
      rd_data   <= '0;
      s_data_q  <= 1'b0;
      term_done <= 1'b0;
    end else begin
      s_data_q <= bus.s_data;
      case (state)
        IDLE: begin
          term_done <= 1'b0;
          if (hit) ptr <= bus.addr[DEPTH_LOG2+BYTE_LOG2-1:BYTE_LOG2];
        end
        RD_FETCH: begin
          rd_data <= mem[ptr];
        end
        WRITE, READ: begin
          if (phase_done) begin
            if (last_phase) begin
              term_done <= 1'b1;
            end else begin
              ptr <= ptr + DEPTH_LOG2'(1);
              if (state == READ) rd_data <= mem[ptr + DEPTH_LOG2'(1)];
            end
          end
        end
        DRAIN: begin
          term_done <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && state == WRITE && phase_done) begin
      for (int b = 0; b < BYTES; b++) begin
        if (!bus.s_cbe[b]) mem[ptr][b*8 +: 8] <= bus.adio_out[b*8 +: 8];
      end
    end
  end

  assign bus.adio_in = rd_data;
  assign bus.c_ready = c_ready;
  assign bus.c_term  = c_term;
  assign bus.oe_adio = oe_adio;
endmodule

// File: tb/tb_pci_target_mem_if.sv
// Randomized bench for pci_target_mem_if: a transaction-level memory model predicts
// every data-window cycle, plus literal checks for the key scenarios.
module tb_pci_target_mem_if;
  localparam int DATA_W     = 32;
  localparam int DEPTH_LOG2 = 10;
  localparam int MAX_BURST  = 16;
  localparam int DEPTH      = 1 << DEPTH_LOG2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pci_target_mem_if_if #(.DATA_W(DATA_W)) bus ();

  pci_target_mem_if #(
    .DATA_W(DATA_W),
    .DEPTH_LOG2(DEPTH_LOG2),
    .MAX_BURST(MAX_BURST)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  logic [31:0] model_mem [DEPTH];
  int          total = 0;
  int          bad   = 0;

  logic        chk_en = 1'b0;
  logic        exp_ready, exp_term, exp_oe, exp_dv;
  logic [31:0] exp_data;

  logic [31:0] rd_cap [$];
  logic [31:0] wdata_q [$];
  int          dut_phases;
  int          dut_term_phase;
  int          cbe_mode;
  logic [3:0]  cbe_fixed;
  bit          always_vld;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  function automatic bit is_last(input int w, input int idx);
    bit r;
    r = (w == DEPTH - 1);
`ifdef PCI_MEM_BURST_LIMIT_EN
    if (idx == MAX_BURST - 1) r = 1'b1;
`endif
    return r;
  endfunction

  // Compare every cycle against the expectations set by the driver, and record
  // what the DUT actually delivered so literal checks can inspect it.
  always @(negedge clk) begin
    if (chk_en) begin
      check_output("c_ready", {31'b0, bus.c_ready}, {31'b0, exp_ready});
      check_output("c_term",  {31'b0, bus.c_term},  {31'b0, exp_term});
      check_output("oe_adio", {31'b0, bus.oe_adio}, {31'b0, exp_oe});
      if (exp_dv) check_output("adio_in", bus.adio_in, exp_data);
      if (bus.c_ready && bus.s_data_vld) begin
        dut_phases++;
        if (bus.oe_adio) rd_cap.push_back(bus.adio_in);
        if (bus.c_term && dut_term_phase < 0) dut_term_phase = dut_phases;
      end
    end
  end

  task automatic idle_inputs();
    bus.base_hit   = 1'b0;
    bus.addr_vld   = 1'b0;
    bus.addr       = '0;
    bus.s_wrdn     = 1'b0;
    bus.s_data     = 1'b0;
    bus.s_data_vld = 1'b0;
    bus.s_cbe      = '0;
    bus.adio_out   = '0;
  endtask

  task automatic expect_quiet();
    exp_ready = 1'b0;
    exp_term  = 1'b0;
    exp_oe    = 1'b0;
    exp_dv    = 1'b0;
    exp_data  = '0;
  endtask

  // One complete burst: address phase, n master data phases, s_data drop, drain.
  // rst_at >= 0 pulls rst_n low together with that data phase.
  task automatic apply_stimulus(input bit wr, input int word, input int n, input int rst_at);
    int          idx;
    int          k;
    bit          done;
    bit          vld;
    logic [31:0] a;
    logic [31:0] wd;
    logic [3:0]  cbe;
    idx  = 0;
    k    = 0;
    done = 1'b0;
    rd_cap.delete();
    dut_phases     = 0;
    dut_term_phase = -1;

    @(posedge clk); #1;
    a = $urandom();
    a[11:2] = word[9:0];
    idle_inputs();
    bus.base_hit = 1'b1;
    bus.addr_vld = 1'b1;
    bus.addr     = a;
    bus.s_wrdn   = wr;
    expect_quiet();
    chk_en = 1'b1;

    if (!wr) begin
      @(posedge clk); #1;
      idle_inputs();
      bus.s_data = 1'b1;
      expect_quiet();
    end

    while (k < n) begin
      @(posedge clk); #1;
      bus.base_hit   = ($urandom_range(0, 3) == 0);
      bus.addr_vld   = bus.base_hit;
      bus.addr       = $urandom();
      bus.s_wrdn     = 1'($urandom_range(0, 1));
      bus.s_data     = 1'b1;
      vld            = always_vld || ($urandom_range(0, 3) != 0);
      wd             = (wdata_q.size() > 0) ? wdata_q.pop_front() : $urandom();
      case (cbe_mode)
        1:       cbe = 4'($urandom_range(0, 15));
        2:       cbe = cbe_fixed;
        default: cbe = 4'b0000;
      endcase
      bus.s_data_vld = vld;
      bus.adio_out   = wd;
      bus.s_cbe      = cbe;

      exp_ready = !done;
      exp_term  = done || is_last(word + idx, idx);
      exp_oe    = !wr;
      exp_dv    = !wr && !done;
      exp_data  = model_mem[word + idx];

      if (rst_at == k && vld) rst_n = 1'b0;
      if (vld) begin
        k++;
        if (!done && rst_n) begin
          if (wr) begin
            for (int b = 0; b < 4; b++) begin
              if (!cbe[b]) model_mem[word + idx][b*8 +: 8] = wd[b*8 +: 8];
            end
          end
          if (exp_term) done = 1'b1;
          else idx++;
        end
      end
      if (!rst_n) break;
    end

    if (!rst_n) begin
      @(posedge clk); #1;
      rst_n = 1'b1;
      idle_inputs();
      expect_quiet();
      exp_dv   = 1'b1;
      exp_data = '0;
      @(posedge clk); #1;
      expect_quiet();
      chk_en = 1'b0;
      return;
    end

    @(posedge clk); #1;
    idle_inputs();
    expect_quiet();
    @(posedge clk); #1;
    expect_quiet();
  endtask

  initial begin
    idle_inputs();
    expect_quiet();
    cbe_mode   = 0;
    cbe_fixed  = 4'b0000;
    always_vld = 1'b0;
    rst_n      = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_output("rst_c_ready", {31'b0, bus.c_ready}, 32'd0);
    check_output("rst_c_term",  {31'b0, bus.c_term},  32'd0);
    check_output("rst_oe_adio", {31'b0, bus.oe_adio}, 32'd0);
    check_output("rst_adio_in", bus.adio_in, 32'd0);
    rst_n = 1'b1;

    // Fill the whole memory so every later read has a defined expectation.
    for (int w = 0; w < DEPTH; w += 16) apply_stimulus(1'b1, w, 16, -1);

    // Four-word write at byte 0x100 then immediate zero-wait read-back.
    always_vld = 1'b1;
    wdata_q = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    apply_stimulus(1'b1, 'h40, 4, -1);
    apply_stimulus(1'b0, 'h40, 4, -1);
    check_output("rd22_count", rd_cap.size(), 32'd4);
    if (rd_cap.size() == 4) begin
      check_output("rd22_w0", rd_cap[0], 32'h11111111);
      check_output("rd22_w1", rd_cap[1], 32'h22222222);
      check_output("rd22_w2", rd_cap[2], 32'h33333333);
      check_output("rd22_w3", rd_cap[3], 32'h44444444);
    end

    // Partial byte write over zero.
    wdata_q = '{32'h00000000};
    apply_stimulus(1'b1, 'h80, 1, -1);
    cbe_mode  = 2;
    cbe_fixed = 4'b1010;
    wdata_q = '{32'hAABBCCDD};
    apply_stimulus(1'b1, 'h80, 1, -1);
    cbe_mode = 0;
    apply_stimulus(1'b0, 'h80, 1, -1);
    check_output("cbe_merge", (rd_cap.size() > 0) ? rd_cap[0] : 32'hDEAD0000, 32'h00BB00DD);

    // All byte enables off: memory unchanged, phase still consumed.
    cbe_mode  = 2;
    cbe_fixed = 4'b1111;
    wdata_q = '{32'h5A5A5A5A};
    apply_stimulus(1'b1, 'h40, 1, -1);
    check_output("cbe_off_phase", dut_phases, 32'd1);
    cbe_mode = 0;
    apply_stimulus(1'b0, 'h40, 1, -1);
    check_output("cbe_off_keep", (rd_cap.size() > 0) ? rd_cap[0] : 32'hDEAD0000, 32'h11111111);

    // Top-of-memory disconnect on a read starting two words from the end.
    apply_stimulus(1'b0, DEPTH - 2, 4, -1);
    check_output("top_term_phase", dut_term_phase, 32'd2);
    check_output("top_rd_count", rd_cap.size(), 32'd2);

    // 20-phase write at 0: only the burst limit (if built in) stops it early.
    apply_stimulus(1'b1, 0, 20, -1);
`ifdef PCI_MEM_BURST_LIMIT_EN
    check_output("limit_term_phase", dut_term_phase, 32'd16);
`else
    check_output("nolimit_term_phase", dut_term_phase, 32'hFFFFFFFF);
`endif
    apply_stimulus(1'b0, 0, 16, -1);
    apply_stimulus(1'b0, 16, 4, -1);

    // Randomized bursts with random waits, enables and stray hits.
    always_vld = 1'b0;
    for (int t = 0; t < 40; t++) begin
      cbe_mode = $urandom_range(0, 1);
      apply_stimulus(1'($urandom_range(0, 1)), $urandom_range(0, DEPTH - 1), $urandom_range(1, 20), -1);
    end
    cbe_mode = 0;

    // Reset during the fourth data phase of a write: that word keeps its old value.
    always_vld = 1'b1;
    wdata_q = '{32'hC0DE0000, 32'hC0DE0001, 32'hC0DE0002, 32'hC0DE0003, 32'hC0DE0004};
    apply_stimulus(1'b1, 'h200, 5, 3);
    wdata_q.delete();
    apply_stimulus(1'b0, 'h200, 4, -1);
    check_output("rst_mid_w2", (rd_cap.size() > 2) ? rd_cap[2] : 32'hDEAD0000, 32'hC0DE0002);
    check_output("rst_mid_w3_kept", {31'b0, (rd_cap.size() > 3) && (rd_cap[3] != 32'hC0DE0003)}, 32'd1);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
